// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled simple dual-port RAM.
package ram_pkg;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
    typedef enum logic {ST_CLEAR, ST_READY} ram_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ram_sdp_lane.sv
// One byte-wide simple dual-port array with registered, read-first output.
module ram_sdp_lane
    import ram_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // stage p0 -> p1: array write and registered read (same-address read sees the old byte)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_sdp_be.sv
// Byte-enabled simple dual-port RAM with zero-fill after reset and selectable read-during-write.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int        DATA_W         = 32,
    parameter int        DEPTH          = 1024,
    parameter int        ADDR_W         = $clog2(DEPTH),
    parameter rdw_mode_e RDW_MODE       = RDW_OLD,
    parameter bit        CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [DATA_W/BYTE_W-1:0] i_be,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_rvalid,
    output logic                     o_busy
);

    localparam int                NB      = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    ram_state_e        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              wr_in_range, rd_in_range;
    logic              wr_ok, rd_ok, lane_re;
    logic [NB-1:0]     lane_we;
    logic [ADDR_W-1:0] lane_waddr;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

    logic              vld_p1;
    logic              zero_p1;
    logic [NB-1:0]     byp_be_p1;
    logic [DATA_W-1:0] wdata_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_in_range = {1'b0, i_waddr} < DEPTH_X;
        rd_in_range = {1'b0, i_raddr} < DEPTH_X;
        wr_ok       = 1'b0;
        rd_ok       = 1'b0;
        lane_we     = '0;
        lane_waddr  = i_waddr;
        lane_wdata  = i_wdata;
        case (state)
            ST_CLEAR: begin
                lane_we    = '1;
                lane_waddr = clr_cnt;
                lane_wdata = '0;
                if (clr_cnt == LAST) begin
                    state_nxt   = ST_READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                wr_ok   = i_we & wr_in_range;
                rd_ok   = i_re;
                lane_we = wr_ok ? i_be : '0;
            end
        endcase
        lane_re = rd_ok & rd_in_range;
    end

    assign o_busy = (state == ST_CLEAR);

    for (genvar k = 0; k < NB; k++) begin : g_lane
        ram_sdp_lane #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[k]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[k*BYTE_W +: BYTE_W]),
            .re    (lane_re),
            .raddr (i_raddr),
            .rdata (lane_rdata[k*BYTE_W +: BYTE_W])
        );
    end

    // stage p0 -> p1: read qualifiers and bypass select travel with the lane read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            zero_p1   <= 1'b1;
            byp_be_p1 <= '0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) begin
                zero_p1   <= ~rd_in_range;
                byp_be_p1 <= (RDW_MODE == RDW_NEW && wr_ok && i_waddr == i_raddr) ? i_be : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_ok) begin
            wdata_p1 <= i_wdata;
        end
    end

    // Output merge: forced zero (reset / out of range), bypassed write byte, or array byte.
    for (genvar k = 0; k < NB; k++) begin : g_merge
        assign o_rdata[k*BYTE_W +: BYTE_W] = zero_p1      ? '0 :
                                             byp_be_p1[k] ? wdata_p1[k*BYTE_W +: BYTE_W] :
                                                            lane_rdata[k*BYTE_W +: BYTE_W];
    end

    assign o_rvalid = vld_p1;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: three instances (clear/old, clear/new depth 12, no-clear).
module tb_ram_sdp_be;
    import ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [3:0]  waddr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        re = 1'b0;
    logic [3:0]  raddr = 4'h0;

    logic [31:0] a_rdata, b_rdata, c_rdata;
    logic        a_rvalid, b_rvalid, c_rvalid;
    logic        a_busy, b_busy, c_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_sdp_be #(.DATA_W(32), .DEPTH(16), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdata(wdata),
        .i_re(re), .i_raddr(raddr), .o_rdata(a_rdata), .o_rvalid(a_rvalid), .o_busy(a_busy));

    ram_sdp_be #(.DATA_W(32), .DEPTH(12), .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdata(wdata),
        .i_re(re), .i_raddr(raddr), .o_rdata(b_rdata), .o_rvalid(b_rvalid), .o_busy(b_busy));

    ram_sdp_be #(.DATA_W(32), .DEPTH(16), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdata(wdata),
        .i_re(re), .i_raddr(raddr), .o_rdata(c_rdata), .o_rvalid(c_rvalid), .o_busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; be = 4'h0; waddr = 4'h0; raddr = 4'h0; wdata = 32'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        idle();
        we = 1'b1; waddr = a; wdata = d; be = b;
    endtask

    task automatic rd(input logic [3:0] a);
        idle();
        re = 1'b1; raddr = a;
    endtask

    initial begin
        // Reset held
        idle();
        step();
        step();
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_a_rvalid", {31'b0, a_rvalid}, 32'h0);
        chk("rst_a_busy", {31'b0, a_busy}, 32'h1);
        chk("rst_b_busy", {31'b0, b_busy}, 32'h1);
        chk("rst_c_busy", {31'b0, c_busy}, 32'h0);
        chk("rst_c_rdata", c_rdata, 32'h0);

        // Release mid-cycle; edge k counted from here
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            idle();
            if (k == 1) wr(4'd5, 32'h0BADF00D, 4'hF);
            if (k == 2) rd(4'd5);
            if (k == 5) wr(4'd3, 32'hFFFFFFFF, 4'hF);
            step();
            chk($sformatf("busy_a_e%0d", k), {31'b0, a_busy}, (k < 16) ? 32'h1 : 32'h0);
            chk($sformatf("busy_b_e%0d", k), {31'b0, b_busy}, (k < 12) ? 32'h1 : 32'h0);
            if (k == 2) begin
                chk("noclr_c_rdata", c_rdata, 32'h0BADF00D);
                chk("noclr_c_rvalid", {31'b0, c_rvalid}, 32'h1);
                chk("busy_a_rvalid", {31'b0, a_rvalid}, 32'h0);
            end
        end

        // Zero-fill result, including address 3 written while busy
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            step();
            chk($sformatf("fill_a_%0d", i), a_rdata, 32'h0);
            chk($sformatf("fill_a_vld_%0d", i), {31'b0, a_rvalid}, 32'h1);
            chk($sformatf("fill_b_%0d", i), b_rdata, 32'h0);
        end

        // Byte-enable merge
        wr(4'd7, 32'hAABBCCDD, 4'hF);
        step();
        wr(4'd7, 32'h11223344, 4'b0101);
        step();
        rd(4'd7);
        step();
        chk("be_a", a_rdata, 32'hAA22CC44);
        chk("be_b", b_rdata, 32'hAA22CC44);

        // Read-during-write, same address
        wr(4'd2, 32'h12345678, 4'hF);
        step();
        wr(4'd2, 32'hFFFFFFFF, 4'b0011);
        re = 1'b1; raddr = 4'd2;
        step();
        chk("rdw_old_a", a_rdata, 32'h12345678);
        chk("rdw_new_b", b_rdata, 32'h1234FFFF);
        rd(4'd2);
        step();
        chk("rdw_after_a", a_rdata, 32'h1234FFFF);
        chk("rdw_after_b", b_rdata, 32'h1234FFFF);

        // No read: data holds, valid drops
        idle();
        step();
        chk("hold_a_rdata", a_rdata, 32'h1234FFFF);
        chk("hold_b_rdata", b_rdata, 32'h1234FFFF);
        chk("hold_a_rvalid", {31'b0, a_rvalid}, 32'h0);

        // Address 13: in range for depth 16, out of range for depth 12
        wr(4'd13, 32'hDEADBEEF, 4'hF);
        step();
        rd(4'd13);
        step();
        chk("oor_a", a_rdata, 32'hDEADBEEF);
        chk("oor_b", b_rdata, 32'h0);
        chk("oor_b_rvalid", {31'b0, b_rvalid}, 32'h1);
        rd(4'd1);
        step();
        chk("oor_b_addr1", b_rdata, 32'h0);

        // Different addresses on the same edge
        wr(4'd4, 32'h55667788, 4'hF);
        re = 1'b1; raddr = 4'd7;
        step();
        chk("indep_a", a_rdata, 32'hAA22CC44);
        chk("indep_b", b_rdata, 32'hAA22CC44);
        rd(4'd4);
        step();
        chk("indep_a_wr", a_rdata, 32'h55667788);
        chk("indep_b_wr", b_rdata, 32'h55667788);

        // Reset mid-clear at counter 9
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) step();
        chk("mid_a_busy", {31'b0, a_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a_rdata", a_rdata, 32'h0);
        chk("mid_rst_a_rvalid", {31'b0, a_rvalid}, 32'h0);
        chk("mid_rst_c_rdata", c_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("restart_busy_a_e%0d", k), {31'b0, a_busy}, (k < 16) ? 32'h1 : 32'h0);
        end
        rd(4'd7);
        step();
        chk("restart_a_cleared", a_rdata, 32'h0);
        chk("restart_b_cleared", b_rdata, 32'h0);
        chk("restart_c_kept", c_rdata, 32'hAA22CC44);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_sdp_be.md
# ram_sdp_be

Parametrised simple dual-port synchronous RAM with one write port, one read port, per-byte write enables, a selectable read-during-write mode and a hardware zero-fill sequencer after reset. It replaces the fixed 4 KB × 8 data RAM in the SoC memory subsystem and backs both the data memory and the peripheral scratch buffers. Storage must infer block RAM: no async reset on the array.

## Interface
- DATA_W, 32, read/write word width; a multiple of 8.
- DEPTH, 1024, words; any value ≥ 2, not required to be a power of two.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- RDW_MODE, RDW_OLD, same-address read-during-write result (RDW_OLD or RDW_NEW).
- CLEAR_ON_RESET, 1, zero-fill the array after reset when 1.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_we  in  1  write request.
- i_be  in  DATA_W/8  byte enables; bit k covers i_wdata[8k+7:8k].
- i_waddr  in  ADDR_W  write word address.
- i_wdata  in  DATA_W  write data.
- i_re  in  1  read request.
- i_raddr  in  ADDR_W  read word address.
- o_rdata  out  DATA_W  registered read data.
- o_rvalid  out  1  o_rdata updated by a read accepted on the previous edge.
- o_busy  out  1  zero-fill in progress; all requests ignored.

## Operation
- FSM, two states: CLEAR, READY. Reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
- CLEAR: clear counter starts at 0; each edge writes all-zero to address counter, increments. Edge writing DEPTH-1 moves to READY. i_we/i_re ignored (no write, no o_rvalid).
- rst_n asserted mid-clear: counter returns to 0, clear restarts from address 0 after release.
- READY write: when i_we=1 and address < DEPTH, byte k of word i_waddr takes i_wdata byte k for each i_be[k]=1; other bytes unchanged. i_be all zero means no write.
- READY read: when i_re=1, o_rdata <= word at i_raddr; o_rvalid <= 1. When i_re=0, o_rdata holds, o_rvalid <= 0.
- Out-of-range (address ≥ DEPTH): write dropped; read returns 0 with o_rvalid=1.
- Read and write same address, same edge:
  - RDW_OLD: o_rdata is the pre-write word.
  - RDW_NEW: o_rdata is the merged word: enabled bytes from i_wdata, others from the pre-write word.
- Different addresses same edge: independent, no interaction.

## Timing
- Reset values: o_rdata = 0, o_rvalid = 0, o_busy = CLEAR_ON_RESET.
- Read latency 1 edge: request sampled at edge N, o_rdata/o_rvalid valid after edge N.
- Write visible to a read sampled at the next edge (N+1), any mode.
- Zero-fill: o_busy high for exactly DEPTH rising edges after rst_n release; deasserts after edge DEPTH. The first request accepted is the one sampled at edge DEPTH+1.
- o_busy is registered; no combinational path from any input to any output.
- RDW_NEW bypass: realise with a registered bypass select plus registered merged word, not a combinational array read-through.

## Structure
- Package ram_pkg: enum rdw_mode_e {RDW_OLD, RDW_NEW}; enum ram_state_e {ST_CLEAR, ST_READY}; constant BYTE_W = 8.
- Sub-module ram_sdp_lane: one 8-bit-wide, DEPTH-deep simple dual-port array with a single write enable and registered read. ram_sdp_be instantiates DATA_W/8 lanes in a generate loop. The FSM, clear counter, range checks and RDW bypass live in the top.

## Test plan
- Reset release, DEPTH=16, CLEAR_ON_RESET=1 -> o_busy high 16 edges; i_we at edge 5 with data 0xFFFFFFFF to addr 3 ignored; after clear, reads of 0..15 all return 0x00000000 with o_rvalid=1.
- Write 0xAABBCCDD to addr 7, i_be=4'b1111; then write 0x11223344 to addr 7, i_be=4'b0101 -> read addr 7 returns 0xAA22CC44.
- RDW_OLD: addr 2 holds 0x12345678; same edge write 0xFFFFFFFF, i_be=4'b0011, read addr 2 -> 0x12345678; next read -> 0x1234FFFF. Repeat with RDW_NEW -> 0x1234FFFF on the first read.
- DEPTH=12: write 0xDEADBEEF to addr 13 -> no array change; read addr 13 -> 0x00000000, o_rvalid=1.
- Assert rst_n at clear counter 9, release -> o_busy restarts; full DEPTH edges counted from release; o_rdata=0, o_rvalid=0 during reset.
- CLEAR_ON_RESET=0 -> o_busy=0 from reset; write at first edge is accepted; read of that address at second edge returns the written word.
